// File: rtl/dsp_sequencer.sv
// Fetch/execute controller for a TMS32010-style DSP datapath: latches each
// instruction into IR, drives one cycle of datapath controls, sequences branches.
module dsp_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             hold,
    input  logic [15:0]      instruction,
    input  logic             acc_zero,
    output logic             pc_en,
    output logic [1:0]       pcInMux_ctrl,
    output logic [2:0]       alu_ctrl,
    output logic [1:0]       aluInMux_ctrl,
    output logic [2:0]       accumInMux_ctrl,
    output logic [1:0]       databus_ctrl,
    output logic             multInMux_ctrl,
    output logic             tReg_ctrl,
    output logic             pReg_ctrl,
    output logic             dataRamIn_ctrl,
    output logic             dataWrEn_ctrl,
    output logic             enable_acc,
    output logic             accumReset_ctrl,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, BR_ADDR, HALT} state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_LAC, OP_SACL, OP_LT, OP_MPY, OP_ZAC,
        OP_PAC, OP_APAC, OP_NOP, OP_B, OP_BZ, OP_ILL
    } op_t;

    localparam logic [15:0] NOP_WORD = 16'h7F80;

    state_t            state, state_next;
    op_t               op;
    logic [15:0]       ir;
    logic              load_ir;
    logic              count_en;

    // Classify the latched instruction word once so the control table below stays flat.
    always_comb begin
        op = OP_ILL;
        case (ir[15:12])
            4'h0: op = OP_ADD;
            4'h1: op = OP_SUB;
            4'h2: op = OP_LAC;
            default: begin
                if (ir[15:8] == 8'h50)
                    op = OP_SACL;
                else if (ir[15:8] == 8'h6A)
                    op = OP_LT;
                else if (ir[15:8] == 8'h6D)
                    op = OP_MPY;
                else begin
                    case (ir)
                        16'h7F89: op = OP_ZAC;
                        16'h7F8E: op = OP_PAC;
                        16'h7F8F: op = OP_APAC;
                        16'h7F80: op = OP_NOP;
                        16'hF900: op = OP_B;
                        16'hF600: op = OP_BZ;
                        default:  op = OP_ILL;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        state_next      = state;
        load_ir         = 1'b0;
        count_en        = 1'b0;
        pc_en           = 1'b0;
        pcInMux_ctrl    = 2'd0;
        alu_ctrl        = 3'd0;
        aluInMux_ctrl   = 2'd0;
        accumInMux_ctrl = 3'd0;
        databus_ctrl    = 2'd0;
        multInMux_ctrl  = 1'b0;
        tReg_ctrl       = 1'b0;
        pReg_ctrl       = 1'b0;
        dataRamIn_ctrl  = 1'b0;
        dataWrEn_ctrl   = 1'b0;
        enable_acc      = 1'b0;
        accumReset_ctrl = 1'b0;

        case (state)
            IDLE: begin
                if (run)
                    state_next = FETCH;
            end
            FETCH: begin
                if (!hold) begin
                    load_ir      = 1'b1;
                    pc_en        = 1'b1;
                    pcInMux_ctrl = 2'd3;
                    state_next   = EXEC;
                end
            end
            EXEC: begin
                count_en   = 1'b1;
                state_next = FETCH;
                case (op)
                    OP_ADD, OP_SUB: begin
                        databus_ctrl   = 2'd1;
                        dataRamIn_ctrl = 1'b1;
                        alu_ctrl       = (op == OP_SUB) ? 3'd1 : 3'd0;
                        enable_acc     = 1'b1;
                    end
                    OP_LAC: begin
                        databus_ctrl    = 2'd1;
                        dataRamIn_ctrl  = 1'b1;
                        accumInMux_ctrl = 3'd1;
                        enable_acc      = 1'b1;
                    end
                    OP_SACL: begin
                        databus_ctrl   = 2'd2;
                        dataRamIn_ctrl = 1'b1;
                        dataWrEn_ctrl  = 1'b1;
                    end
                    OP_LT: begin
                        databus_ctrl   = 2'd1;
                        dataRamIn_ctrl = 1'b1;
                        tReg_ctrl      = 1'b1;
                    end
                    OP_MPY: begin
                        databus_ctrl   = 2'd1;
                        dataRamIn_ctrl = 1'b1;
                        pReg_ctrl      = 1'b1;
                    end
                    OP_ZAC:  accumReset_ctrl = 1'b1;
                    OP_PAC: begin
                        accumInMux_ctrl = 3'd2;
                        enable_acc      = 1'b1;
                    end
                    OP_APAC: begin
                        aluInMux_ctrl = 2'd1;
                        enable_acc    = 1'b1;
                    end
                    OP_NOP: ;
                    // Branches retire only after their target word is consumed.
                    OP_B, OP_BZ: begin
                        count_en   = 1'b0;
                        state_next = BR_ADDR;
                    end
                    default: begin
                        count_en   = 1'b0;
                        state_next = HALT;
                    end
                endcase
            end
            BR_ADDR: begin
                pc_en        = 1'b1;
                pcInMux_ctrl = (op == OP_B || acc_zero) ? 2'd0 : 2'd3;
                count_en     = 1'b1;
                state_next   = FETCH;
            end
            HALT: ;
            default: state_next = IDLE;
        endcase
    end

    assign busy   = (state != IDLE) && (state != HALT);
    assign halted = (state == HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ir      <= NOP_WORD;
            retired <= '0;
        end else begin
            state <= state_next;
            if (load_ir)
                ir <= instruction;
            if (count_en)
                retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dsp_sequencer.sv
// Self-checking bench for dsp_sequencer: per-cycle expected controls go into a
// scoreboard when stimulus is driven and are compared on the falling edge.
module tb_dsp_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          hold;
    logic [15:0]   instruction;
    logic          acc_zero;
    logic          pc_en;
    logic [1:0]    pcInMux_ctrl;
    logic [2:0]    alu_ctrl;
    logic [1:0]    aluInMux_ctrl;
    logic [2:0]    accumInMux_ctrl;
    logic [1:0]    databus_ctrl;
    logic          multInMux_ctrl;
    logic          tReg_ctrl;
    logic          pReg_ctrl;
    logic          dataRamIn_ctrl;
    logic          dataWrEn_ctrl;
    logic          enable_acc;
    logic          accumReset_ctrl;
    logic          busy;
    logic          halted;
    logic [CW-1:0] retired;

    dsp_sequencer #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .run(run), .hold(hold),
        .instruction(instruction), .acc_zero(acc_zero),
        .pc_en(pc_en), .pcInMux_ctrl(pcInMux_ctrl), .alu_ctrl(alu_ctrl),
        .aluInMux_ctrl(aluInMux_ctrl), .accumInMux_ctrl(accumInMux_ctrl),
        .databus_ctrl(databus_ctrl), .multInMux_ctrl(multInMux_ctrl),
        .tReg_ctrl(tReg_ctrl), .pReg_ctrl(pReg_ctrl),
        .dataRamIn_ctrl(dataRamIn_ctrl), .dataWrEn_ctrl(dataWrEn_ctrl),
        .enable_acc(enable_acc), .accumReset_ctrl(accumReset_ctrl),
        .busy(busy), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [19:0] obsCtrl;
    assign obsCtrl = {pc_en, pcInMux_ctrl, alu_ctrl, aluInMux_ctrl, accumInMux_ctrl,
                      databus_ctrl, multInMux_ctrl, tReg_ctrl, pReg_ctrl,
                      dataRamIn_ctrl, dataWrEn_ctrl, enable_acc, accumReset_ctrl};

    typedef struct packed {
        logic [19:0]   ctrl;
        logic          busy;
        logic          halted;
        logic [CW-1:0] ret;
    } exp_t;

    exp_t    sbQ[$];
    string   tagQ[$];
    int      nChecks = 0;
    int      nPass   = 0;
    logic [CW-1:0] expRet;

    logic [19:0] E_ADD, E_SUB, E_LAC, E_SACL, E_LT, E_MPY, E_ZAC, E_PAC, E_APAC;
    logic [19:0] E_NONE, V_FETCH, V_TAKEN;

    function automatic logic [19:0] mk(input logic pe, input logic [1:0] pim,
                                       input logic [2:0] alu, input logic [1:0] ain,
                                       input logic [2:0] acc, input logic [1:0] db,
                                       input logic mi, input logic tr, input logic pr,
                                       input logic ri, input logic we, input logic ea,
                                       input logic ar);
        return {pe, pim, alu, ain, acc, db, mi, tr, pr, ri, we, ea, ar};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp)
            nPass++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Scoreboard consumer: one expected record per driven cycle.
    always @(negedge clk) begin
        if (sbQ.size() != 0) begin
            exp_t  e;
            string t;
            e = sbQ.pop_front();
            t = tagQ.pop_front();
            checkOutput({t, "_ctrl"},    32'(obsCtrl), 32'(e.ctrl));
            checkOutput({t, "_busy"},    32'(busy),    32'(e.busy));
            checkOutput({t, "_halted"},  32'(halted),  32'(e.halted));
            checkOutput({t, "_retired"}, 32'(retired), 32'(e.ret));
        end
    end

    task automatic applyStimulus(input logic [15:0] instr, input logic h, input logic az,
                                 input logic r, input logic [19:0] ec, input logic eb,
                                 input logic eh, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        instruction = instr;
        hold        = h;
        acc_zero    = az;
        run         = r;
        e.ctrl   = ec;
        e.busy   = eb;
        e.halted = eh;
        e.ret    = expRet;
        sbQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    // EXEC drives 0xFFFF on the bus so decoding the bus instead of IR would halt.
    task automatic runSingle(input logic [15:0] instr, input logic [19:0] ec, input string tag);
        applyStimulus(instr, 1'b0, 1'b0, 1'b0, V_FETCH, 1'b1, 1'b0, {tag, "_fetch"});
        applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b0, ec, 1'b1, 1'b0, {tag, "_exec"});
        expRet = expRet + 1'b1;
    endtask

    task automatic runBranch(input logic [15:0] op, input logic [15:0] tgt, input logic az,
                             input logic taken, input string tag);
        applyStimulus(op, 1'b0, 1'b0, 1'b0, V_FETCH, 1'b1, 1'b0, {tag, "_fetch"});
        applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b0, E_NONE, 1'b1, 1'b0, {tag, "_exec"});
        applyStimulus(tgt, 1'b1, az, 1'b0, taken ? V_TAKEN : V_FETCH, 1'b1, 1'b0, {tag, "_braddr"});
        expRet = expRet + 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        E_ADD   = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0);
        E_SUB   = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0);
        E_LAC   = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0);
        E_SACL  = mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 1, 0, 0);
        E_LT    = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        E_MPY   = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        E_ZAC   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        E_PAC   = mk(0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0);
        E_APAC  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        E_NONE  = '0;
        V_FETCH = mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        V_TAKEN = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        reset = 1'b1; run = 1'b0; hold = 1'b0; instruction = 16'h0; acc_zero = 1'b0;
        expRet = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ctrl",    32'(obsCtrl), 32'(0));
        checkOutput("rst_busy",    32'(busy),    32'(0));
        checkOutput("rst_retired", 32'(retired), 32'(0));
        reset = 1'b0;

        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1, E_NONE, 1'b0, 1'b0, "idle");

        runSingle(16'h2005, E_LAC,  "lac");
        runSingle(16'h0006, E_ADD,  "add");
        runSingle(16'h5007, E_SACL, "sacl");

        runBranch(16'hF600, 16'h0040, 1'b1, 1'b1, "bz_taken");
        runBranch(16'hF600, 16'h0040, 1'b0, 1'b0, "bz_skip");
        runBranch(16'hF900, 16'h0123, 1'b0, 1'b1, "b");

        for (int i = 0; i < 4; i++)
            applyStimulus(16'hFFFF, 1'b1, 1'b0, 1'b0, E_NONE, 1'b1, 1'b0, "hold");
        runSingle(16'h0006, E_ADD, "add_after_hold");

        runSingle(16'h6A01, E_LT,   "lt");
        runSingle(16'h6D02, E_MPY,  "mpy");
        runSingle(16'h7F8E, E_PAC,  "pac");
        runSingle(16'h1003, E_SUB,  "sub");
        runSingle(16'h7F89, E_ZAC,  "zac");
        runSingle(16'h7F8F, E_APAC, "apac");

        // Asynchronous reset landing in the middle of a SACL write.
        applyStimulus(16'h5008, 1'b0, 1'b0, 1'b0, V_FETCH, 1'b1, 1'b0, "sacl2_fetch");
        @(posedge clk);
        #1;
        instruction = 16'hFFFF;
        checkOutput("sacl2_wren_before", 32'(dataWrEn_ctrl), 32'(1));
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midrst_wren",    32'(dataWrEn_ctrl), 32'(0));
        checkOutput("midrst_ctrl",    32'(obsCtrl),       32'(0));
        checkOutput("midrst_busy",    32'(busy),          32'(0));
        checkOutput("midrst_retired", 32'(retired),       32'(0));
        expRet = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1, E_NONE, 1'b0, 1'b0, "idle2");
        for (int i = 0; i < 17; i++)
            runSingle(16'h7F80, E_NONE, "nop");

        applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b0, V_FETCH, 1'b1, 1'b0, "ill_fetch");
        applyStimulus(16'h7F80, 1'b0, 1'b0, 1'b0, E_NONE, 1'b1, 1'b0, "ill_exec");
        for (int i = 0; i < 4; i++)
            applyStimulus(16'h7F80, 1'b0, 1'b1, logic'(i % 2 == 0), E_NONE, 1'b0, 1'b1, "halt");

        @(negedge clk);
        #1;
        checkOutput("sb_drained", 32'(sbQ.size()), 32'(0));
        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
